regfile_dump: RTL

- Read-side engine for the 32x32 CPU register file.
- On `start`, walks a contiguous (wrapping) index range through one register-file read port.
- Streams each `{index, value}` pair out over a valid/ready handshake.
- Used by the debug/trace path to snapshot architectural state without stalling the datapath's own read ports.

---
 rtl/regfile_dump.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: read-side dump engine for the 32x32 CPU register file.
// Walks a wrapping index range [first_idx..last_idx] through one asynchronous
// register-file read port. Each {index, value} pair leaves over a
// valid/ready handshake, and done pulses once after the last word.
// Optional build macro REGFILE_DUMP_NZ_EN: words whose captured value is zero
// are skipped and never presented on the output.
//
// state | meaning
// IDLE  | waiting for start; rf_ra parked at 0
// LOAD  | reading rf[ptr] to capture the first word of a (re)started run
// SEND  | word presented; rf_ra looks ahead to ptr+1 for back-to-back capture
// FIN   | one-cycle done pulse, then back to IDLE
module regfile_dump #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] last;
  logic [AW-1:0] ptr_nxt;

  assign ptr_nxt = ptr + AW'(1);

  // Read address and status decode straight from registered state.
  always_comb begin
    rf_ra = '0;
    case (state)
      LOAD:    rf_ra = ptr;
      SEND:    rf_ra = ptr_nxt;
      default: rf_ra = '0;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // Dump sequencer: range latch, word capture and handshake tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= first_idx;
            last  <= last_idx;
            state <= LOAD;
          end
        end
        LOAD: begin
`ifdef REGFILE_DUMP_NZ_EN
          if (rf_rd == '0) begin
            if (ptr == last) state <= FIN;
            else             ptr   <= ptr_nxt;
          end else begin
            out_data  <= rf_rd;
            out_idx   <= ptr;
            out_valid <= 1'b1;
            state     <= SEND;
          end
`else
          out_data  <= rf_rd;
          out_idx   <= ptr;
          out_valid <= 1'b1;
          state     <= SEND;
`endif
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (ptr == last) begin
              out_valid <= 1'b0;
              state     <= FIN;
            end else begin
`ifdef REGFILE_DUMP_NZ_EN
              if (rf_rd == '0) begin
                // ptr+1 is already known to be zero, so resume the walk past it.
                out_valid <= 1'b0;
                if (ptr_nxt == last) begin
                  state <= FIN;
                end else begin
                  ptr   <= ptr_nxt + AW'(1);
                  state <= LOAD;
                end
              end else begin
                ptr      <= ptr_nxt;
                out_data <= rf_rd;
                out_idx  <= ptr_nxt;
              end
`else
              ptr      <= ptr_nxt;
              out_data <= rf_rd;
              out_idx  <= ptr_nxt;
`endif
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
